spi_transaction: RTL and testbench

Transaction sequencer sitting directly upstream of the `spi` byte controller. Accepts one register-access command (read/write, 6-bit address, byte count), emits the header byte with read and multi-byte flags, then streams write payload bytes in or read bytes out. Drives the controller's `tx_request`/`rx_request` handshake and waits for `active` to fall before reporting completion. Used by sensor front-ends (e.g. the on-board accelerometer) that need burst register access.

---
 rtl/spi_pkg.sv | 16 +
 rtl/spi_transaction.sv | 92 +++++++++
 tb/tb_spi_transaction.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// spi_pkg: shared types and constants for the SPI transaction sequencer.
package spi_pkg;
  localparam int SPI_READ_BIT = 7;
  localparam int SPI_MULTI_BIT = 6;
  localparam int SPI_ADDR_W = 6;
  typedef logic [7:0] spi_byte_t;
  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_WR_FETCH,
    S_WR_REQ,
    S_RD_REQ,
    S_RD_WAIT,
    S_DRAIN
  } spi_txn_state_t;
endpackage

// File: rtl/spi_transaction.sv
// spi_transaction: sequences one register-access command (header + burst payload) onto the spi byte controller.
module spi_transaction
  import spi_pkg::*;
#(
  parameter int MAX_BYTES = 6,
  parameter int CW = $clog2(MAX_BYTES + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_read,
  input  logic [SPI_ADDR_W-1:0] cmd_addr,
  input  logic [CW-1:0]         cmd_count,
  input  spi_byte_t             wr_data,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  output spi_byte_t             rd_data,
  output logic                  rd_valid,
  output logic                  rd_last,
  output logic                  busy,
  output logic                  done,
  output logic                  spi_tx_request,
  output spi_byte_t             spi_tx_data,
  output logic                  spi_rx_request,
  input  logic                  spi_ack_request,
  input  logic                  spi_active,
  input  spi_byte_t             spi_rx_data,
  input  logic                  spi_rx_valid
);
  spi_txn_state_t state, next;
  logic rd_q;
  logic [CW-1:0] remaining, cnt_sat;
  spi_byte_t hdr;
  logic last_byte;
  assign cnt_sat = cmd_count > CW'(MAX_BYTES) ? CW'(MAX_BYTES) : cmd_count;
  assign last_byte = remaining == CW'(1);
  always_comb begin
    hdr = '0;
    hdr[SPI_READ_BIT] = cmd_read;
    hdr[SPI_MULTI_BIT] = cmd_count > CW'(1);
    hdr[SPI_ADDR_W-1:0] = cmd_addr;
  end
  always_comb begin
    next = state;
    case (state)
      S_IDLE:     next = cmd_valid ? S_HDR : S_IDLE;
      S_HDR:      if (spi_ack_request) next = remaining == '0 ? S_DRAIN : rd_q ? S_RD_REQ : S_WR_FETCH;
      S_WR_FETCH: if (wr_valid) next = S_WR_REQ;
      S_WR_REQ:   if (spi_ack_request) next = last_byte ? S_DRAIN : S_WR_FETCH;
      S_RD_REQ:   if (spi_ack_request) next = S_RD_WAIT;
      S_RD_WAIT:  if (spi_rx_valid) next = last_byte ? S_DRAIN : S_RD_REQ;
      S_DRAIN:    if (!spi_active && !spi_ack_request) next = S_IDLE;
      default:    next = S_IDLE;
    endcase
  end
  assign cmd_ready = state == S_IDLE;
  assign busy = state != S_IDLE;
  assign wr_ready = state == S_WR_FETCH;
  assign spi_tx_request = state == S_HDR || state == S_WR_REQ;
  assign spi_rx_request = state == S_RD_REQ;
  // done is combinational so busy drops on the edge that ends the done cycle
  assign done = state == S_DRAIN && !spi_active && !spi_ack_request;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      rd_q <= 1'b0;
      remaining <= '0;
      spi_tx_data <= '0;
      rd_data <= '0;
      rd_valid <= 1'b0;
      rd_last <= 1'b0;
    end else begin
      state <= next;
      rd_valid <= 1'b0;
      rd_last <= 1'b0;
      if (state == S_IDLE && cmd_valid) begin
        rd_q <= cmd_read;
        remaining <= cnt_sat;
        spi_tx_data <= hdr;
      end
      if (state == S_WR_FETCH && wr_valid) spi_tx_data <= wr_data;
      if ((state == S_WR_REQ && spi_ack_request) || (state == S_RD_WAIT && spi_rx_valid))
        remaining <= remaining - CW'(1);
      if (state == S_RD_WAIT && spi_rx_valid) begin
        rd_data <= spi_rx_data;
        rd_valid <= 1'b1;
        rd_last <= last_byte;
      end
    end
  end
endmodule

// File: tb/tb_spi_transaction.sv
// tb_spi_transaction: scoreboard bench with a behavioural spi controller and secondary mimic.
module tb_spi_transaction;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic cmd_valid = 1'b0, cmd_read = 1'b0;
  logic [5:0] cmd_addr = '0;
  logic [2:0] cmd_count = '0;
  logic [7:0] wr_data = '0;
  logic wr_valid = 1'b0;
  logic cmd_ready, wr_ready, rd_valid, rd_last, busy, done, spi_tx_request, spi_rx_request;
  logic [7:0] rd_data, spi_tx_data;
  logic spi_ack_request = 1'b0, spi_active = 1'b0, spi_rx_valid = 1'b0;
  logic [7:0] spi_rx_data = '0;
  always #5 clk = ~clk;
  spi_transaction dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_read(cmd_read),
    .cmd_addr(cmd_addr), .cmd_count(cmd_count), .wr_data(wr_data), .wr_valid(wr_valid),
    .wr_ready(wr_ready), .rd_data(rd_data), .rd_valid(rd_valid), .rd_last(rd_last), .busy(busy),
    .done(done), .spi_tx_request(spi_tx_request), .spi_tx_data(spi_tx_data),
    .spi_rx_request(spi_rx_request), .spi_ack_request(spi_ack_request), .spi_active(spi_active),
    .spi_rx_data(spi_rx_data), .spi_rx_valid(spi_rx_valid)
  );
  localparam int K_TX = 0, K_RXREQ = 1, K_RD = 2, K_DONE = 3;
  typedef struct {
    int kind;
    logic [7:0] data;
    logic last;
  } ev_t;
  ev_t exp_q[$];
  int checks = 0, fails = 0, rx_acks = 0;
  logic [7:0] mimic [6] = '{8'hA3, 8'h11, 8'h22, 8'h33, 8'h44, 8'h5A};
  // controller model: one-cycle ack, rx byte 4 cycles after rx ack, active drops after 6 quiet cycles
  int rx_dly = 0, idle = 0, idx = 0;
  always @(posedge clk) begin
    spi_ack_request <= (spi_tx_request || spi_rx_request) && !spi_ack_request;
    spi_rx_valid <= 1'b0;
    if (spi_ack_request) begin
      spi_active <= 1'b1;
      idle <= 0;
      if (spi_rx_request) rx_dly <= 4;
    end else if (rx_dly > 0) begin
      rx_dly <= rx_dly - 1;
      if (rx_dly == 1) begin
        spi_rx_valid <= 1'b1;
        spi_rx_data <= mimic[idx % 6];
        idx <= idx + 1;
      end
    end else if (spi_active) begin
      idle <= idle + 1;
      if (idle == 5) begin
        spi_active <= 1'b0;
        idx <= 0;
      end
    end
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask
  task automatic got(input int kind, input logic [7:0] d, input logic l);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      fails++;
      $display("FAIL unexpected event: got kind=%0d data=%h last=%b, required none", kind, d, l);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.data !== d || e.last !== l) begin
        fails++;
        $display("FAIL event: got kind=%0d data=%h last=%b, required kind=%0d data=%h last=%b",
                 kind, d, l, e.kind, e.data, e.last);
      end
    end
  endtask
  always @(negedge clk) begin
    if (!reset) begin
      if (spi_tx_request && spi_rx_request) chk("one_request", 2'b11, 2'b01);
      if (spi_ack_request && spi_tx_request) got(K_TX, spi_tx_data, 1'b0);
      if (spi_ack_request && spi_rx_request) begin
        got(K_RXREQ, 8'h00, 1'b0);
        rx_acks++;
      end
      if (rd_valid) got(K_RD, rd_data, rd_last);
      if (done) begin
        got(K_DONE, 8'h00, 1'b0);
        chk("done_active_low", spi_active, 0);
      end
    end
  end
  task automatic wait_quiet();
    int t;
    t = 0;
    while (busy && t < 600) begin
      @(posedge clk); #1; t++;
    end
    chk("done_timeout_busy", busy, 0);
    t = 0;
    while (spi_active && t < 100) begin
      @(posedge clk); #1; t++;
    end
    chk("active_timeout", spi_active, 0);
  endtask
  task automatic run_cmd(input logic rd, input logic [5:0] addr, input logic [2:0] cnt,
                         input logic [7:0] hdr, input logic [7:0] pbase, input logic [7:0] pinc,
                         input int gap_at, input logic mid);
    int n, t;
    n = cnt > 6 ? 6 : int'(cnt);
    exp_q.push_back('{K_TX, hdr, 1'b0});
    for (int i = 0; i < n; i++)
      if (rd) begin
        exp_q.push_back('{K_RXREQ, 8'h00, 1'b0});
        exp_q.push_back('{K_RD, mimic[i], i == n - 1});
      end else exp_q.push_back('{K_TX, pbase + pinc * 8'(i), 1'b0});
    exp_q.push_back('{K_DONE, 8'h00, 1'b0});
    chk("ready_before_cmd", cmd_ready, 1);
    cmd_read = rd; cmd_addr = addr; cmd_count = cnt; cmd_valid = 1'b1;
    @(posedge clk); #1 cmd_valid = 1'b0;
    chk("hdr_req", spi_tx_request, 1);
    chk("hdr_data", spi_tx_data, hdr);
    chk("busy_ready", {busy, cmd_ready}, 2'b10);
    if (mid) begin
      @(posedge clk); #1;
      cmd_read = 1'b0; cmd_addr = 6'h3F; cmd_count = 3'd2; cmd_valid = 1'b1;
      @(posedge clk); #1 cmd_valid = 1'b0;
    end
    if (!rd)
      for (int i = 0; i < n; i++) begin
        if (i == gap_at) begin
          repeat (20) @(posedge clk);
          #1 chk("gap_no_req", {spi_tx_request, wr_ready}, 2'b01);
        end
        wr_data = pbase + pinc * 8'(i); wr_valid = 1'b1;
        t = 0;
        while (!wr_ready && t < 300) begin
          @(posedge clk); #1; t++;
        end
        chk("wr_ready", wr_ready, 1);
        @(posedge clk); #1 wr_valid = 1'b0;
      end
    wait_quiet();
    chk("scoreboard_empty", exp_q.size(), 0);
  endtask
  initial begin
    int t, base;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("reset_state", {cmd_ready, busy, done, wr_ready, rd_valid, spi_tx_request, spi_rx_request}, 7'b1000000);
    chk("reset_tx_data", spi_tx_data, 8'h00);
    run_cmd(1'b0, 6'h15, 3'd1, 8'h15, 8'h55, 8'h00, -1, 1'b0);
    run_cmd(1'b1, 6'h15, 3'd1, 8'h95, 8'h00, 8'h00, -1, 1'b0);
    run_cmd(1'b0, 6'h15, 3'd4, 8'h55, 8'h55, 8'h00, 2, 1'b0);
    run_cmd(1'b1, 6'h15, 3'd5, 8'hD5, 8'h00, 8'h00, -1, 1'b1);
    run_cmd(1'b0, 6'h01, 3'd0, 8'h01, 8'h00, 8'h00, -1, 1'b0);
    run_cmd(1'b0, 6'h15, 3'd7, 8'h55, 8'hC0, 8'h03, -1, 1'b0);
    // reset while waiting on the second read byte of a 5-byte burst
    exp_q.push_back('{K_TX, 8'hD5, 1'b0});
    exp_q.push_back('{K_RXREQ, 8'h00, 1'b0});
    exp_q.push_back('{K_RD, 8'hA3, 1'b0});
    exp_q.push_back('{K_RXREQ, 8'h00, 1'b0});
    base = rx_acks;
    cmd_read = 1'b1; cmd_addr = 6'h15; cmd_count = 3'd5; cmd_valid = 1'b1;
    @(posedge clk); #1 cmd_valid = 1'b0;
    t = 0;
    while (rx_acks < base + 2 && t < 300) begin
      @(posedge clk); #1; t++;
    end
    chk("second_rx_ack", rx_acks - base, 2);
    chk("in_rd_wait", {busy, spi_rx_request, spi_tx_request}, 3'b100);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("mid_reset_outputs",
        {cmd_ready, busy, done, wr_ready, rd_valid, rd_last, spi_tx_request, spi_rx_request}, 8'h80);
    chk("mid_reset_data", {spi_tx_data, rd_data}, 16'h0000);
    reset = 1'b0;
    chk("reset_scoreboard", exp_q.size(), 0);
    exp_q.delete();
    wait_quiet();
    run_cmd(1'b1, 6'h15, 3'd1, 8'h95, 8'h00, 8'h00, -1, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
